// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
// Holds the FSM state encoding, the NOP returned on faults and the index width helper.
package imem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;
    localparam int          CNT_W    = 4;

    function automatic int idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/imem_array.sv
// DEPTH x 32 synchronous RAM, one write port and one registered read port.
// Read data appears one edge after rd_en; a same-edge write to the read word returns the old word.
// No backpressure: writes and reads are accepted every cycle.
module imem_array
    import imem_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = idx_w(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [31:0]   wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [31:0]   rd_data
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Contents are never reset; only the output register is, so rsp_data starts at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder for fetch; optional fault checking under IMEM_ERR_CHECK_EN.
// rsp_valid rises WAIT_CYCLES+1 cycles after the request cycle; one transaction in flight.
// Response held stable until rsp_ready; req_ready is low whenever a transaction is in flight.
module imem_responder
    import imem_pkg::*;
#(
    parameter int          DEPTH       = 1024,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [31:0]             req_addr,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [31:0]             rsp_data,
    output logic                    rsp_err,
    input  logic                    ld_en,
    input  logic [idx_w(DEPTH)-1:0] ld_addr,
    input  logic [31:0]             ld_data,
    output logic                    busy
);

    localparam int AW = idx_w(DEPTH);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [AW-1:0]    idx_q, req_idx, rd_addr;
    logic             err_q, rsp_err_q, req_err, err_now;
    logic             accept, enter_resp, rd_en;
    logic [31:0]      off, rd_data;

    // Unsigned subtraction: addresses below BASE_ADDR wrap around.
    assign off     = req_addr - BASE_ADDR;
    assign req_idx = AW'(off >> 2);

`ifdef IMEM_ERR_CHECK_EN
    assign req_err = (req_addr[1:0] != 2'b00) || ((off >> 2) >= 32'(DEPTH));
`else
    assign req_err = 1'b0;
`endif

    assign accept     = (state == IDLE) && req_valid;
    assign enter_resp = (state != RESP) && (state_nxt == RESP);
    assign err_now    = (state == IDLE) ? req_err : err_q;
    assign rd_addr    = (state == IDLE) ? req_idx : idx_q;
    assign rd_en      = enter_resp && !err_now;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    if (WAIT_CYCLES == 0) begin
                        state_nxt = RESP;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = CNT_W'(WAIT_CYCLES - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            idx_q     <= '0;
            err_q     <= 1'b0;
            rsp_err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                idx_q <= req_idx;
                err_q <= req_err;
            end
            if (enter_resp) begin
                rsp_err_q <= err_now;
            end
        end
    end

    imem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (ld_en),
        .wr_addr (ld_addr),
        .wr_data (ld_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);
    assign rsp_err   = rsp_err_q;
    // A faulted access never reads the array, so the NOP is substituted at the output.
    assign rsp_data  = rsp_err_q ? NOP_INSN : rd_data;

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: three instances with WAIT_CYCLES 0, 1 and 2 against a word-array model.
// Build with or without IMEM_ERR_CHECK_EN; expectations follow the same macro.
module tb_imem_responder;

    localparam int          DEPTH = 16;
    localparam int          NW    = 3;
    localparam logic [31:0] BASE  = 32'h0000_1000;

    logic                   clk;
    logic                   reset;
    logic [NW-1:0]          req_valid, req_ready, rsp_valid, rsp_ready, rsp_err, busy;
    logic [NW-1:0][31:0]    req_addr, rsp_data;
    logic                   ld_en;
    logic [3:0]             ld_addr;
    logic [31:0]            ld_data;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] mem_m [DEPTH];

    genvar g;
    for (g = 0; g < NW; g++) begin : g_dut
        imem_responder #(
            .DEPTH       (DEPTH),
            .WAIT_CYCLES (g),
            .BASE_ADDR   (BASE)
        ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_addr  (req_addr[g]),
            .rsp_valid (rsp_valid[g]),
            .rsp_ready (rsp_ready[g]),
            .rsp_data  (rsp_data[g]),
            .rsp_err   (rsp_err[g]),
            .ld_en     (ld_en),
            .ld_addr   (ld_addr),
            .ld_data   (ld_data),
            .busy      (busy[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reference: word index is the byte offset from BASE divided by four.
    function automatic void exp_rsp(input logic [31:0] a, output logic [31:0] d, output logic e);
        logic [31:0] o;
        o = a - BASE;
`ifdef IMEM_ERR_CHECK_EN
        e = (a % 4 != 0) || (o / 4 >= DEPTH);
`else
        e = 1'b0;
`endif
        d = e ? 32'h0000_0013 : mem_m[(o / 4) % DEPTH];
    endfunction

    task automatic load(input logic [3:0] a, input logic [31:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        cyc();
        ld_en = 1'b0;
        mem_m[a] = d;
    endtask

    // One full transaction on instance k; optional load-port write wr_step cycles after the request.
    task automatic txn(input int k, input logic [31:0] addr, input int hold,
                       input bit do_wr, input int wr_step, input logic [3:0] wr_a,
                       input logic [31:0] wr_d);
        logic [31:0] ed;
        logic        ee;
        int          lat;
        // A write committed on an edge before the read edge is visible; on the read edge it is not.
        if (do_wr && wr_step < k) mem_m[wr_a] = wr_d;
        exp_rsp(addr, ed, ee);
        if (do_wr) mem_m[wr_a] = wr_d;

        req_valid[k] = 1'b1; req_addr[k] = addr; rsp_ready[k] = 1'b0;
        check("req_ready_idle", 32'(req_ready[k]), 32'd1);
        lat = 0;
        do begin
            ld_en   = do_wr && (lat == wr_step);
            ld_addr = wr_a;
            ld_data = wr_d;
            cyc();
            lat++;
            req_valid[k] = 1'b0;
            req_addr[k]  = $urandom;
        end while (!rsp_valid[k] && lat < 20);
        ld_en = 1'b0;

        check("latency", 32'(lat), 32'(k + 1));
        check("rsp_data", rsp_data[k], ed);
        check("rsp_err", 32'(rsp_err[k]), 32'(ee));
        check("req_ready_resp", 32'(req_ready[k]), 32'd0);
        check("busy_resp", 32'(busy[k]), 32'd1);
        for (int h = 0; h < hold; h++) begin
            req_valid[k] = 1'b1;
            cyc();
            check("hold_valid", 32'(rsp_valid[k]), 32'd1);
            check("hold_data", rsp_data[k], ed);
            check("hold_req_ready", 32'(req_ready[k]), 32'd0);
        end
        req_valid[k] = 1'b0;
        rsp_ready[k] = 1'b1;
        cyc();
        rsp_ready[k] = 1'b0;
        check("post_valid", 32'(rsp_valid[k]), 32'd0);
        check("post_req_ready", 32'(req_ready[k]), 32'd1);
        check("post_busy", 32'(busy[k]), 32'd0);
        check("post_data_held", rsp_data[k], ed);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] ed, a;
        logic        ee;
        int          ai, nresp, last;
        int          k, wstep;
        bit          dw;
        logic [3:0]  wa;

        req_valid = '0; rsp_ready = '0; req_addr = '0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        reset = 1'b1;
        #1;
        for (int i = 0; i < NW; i++) begin
            check("rst_req_ready", 32'(req_ready[i]), 32'd1);
            check("rst_rsp_valid", 32'(rsp_valid[i]), 32'd0);
            check("rst_rsp_data", rsp_data[i], 32'd0);
            check("rst_rsp_err", 32'(rsp_err[i]), 32'd0);
            check("rst_busy", 32'(busy[i]), 32'd0);
        end
        // Loading works while reset is held too.
        for (int i = 0; i < DEPTH; i++) load(4'(i), (i < 4) ? 32'((i + 1) * 32'h11) : $urandom);
        @(negedge clk);
        reset = 1'b0;
        cyc();

        // Basic read, one wait state.
        txn(1, BASE + 32'h8, 0, 1'b0, 0, 4'd0, 32'd0);
        check("t1_data_const", rsp_data[1], 32'h33);
        // Zero wait states, response back-pressured for three cycles.
        txn(0, BASE + 32'h4, 3, 1'b0, 0, 4'd0, 32'd0);
        check("t2_data_const", rsp_data[0], 32'h22);
        // Load during WAIT is visible; load on the read edge returns the old word.
        txn(2, BASE + 32'hC, 0, 1'b1, 1, 4'd3, 32'hDEAD);
        check("t3_wait_write", rsp_data[2], 32'hDEAD);
        load(4'd3, 32'h44);
        txn(2, BASE + 32'hC, 1, 1'b1, 2, 4'd3, 32'hBEEF);
        check("t3_same_edge", rsp_data[2], 32'h44);
        load(4'd3, 32'h44);

        // Asynchronous reset while in WAIT drops the transaction.
        req_valid[2] = 1'b1; req_addr[2] = BASE + 32'h4;
        cyc();
        req_valid[2] = 1'b0;
        check("t4_in_wait", 32'(busy[2]), 32'd1);
        reset = 1'b1;
        #1;
        check("t4_async_ready", 32'(req_ready[2]), 32'd1);
        check("t4_async_busy", 32'(busy[2]), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("t4_no_rsp", 32'(rsp_valid[2]), 32'd0);
        end
        txn(2, BASE + 32'h0, 0, 1'b0, 0, 4'd0, 32'd0);

        // Fault / wrap addresses; expectations track the macro.
        txn(1, BASE + 32'h6, 0, 1'b0, 0, 4'd0, 32'd0);
        txn(0, BASE + 32'(4 * DEPTH), 0, 1'b0, 0, 4'd0, 32'd0);
        txn(2, BASE + 32'(4 * DEPTH + 4), 1, 1'b0, 0, 4'd0, 32'd0);
        txn(1, BASE - 32'd4, 0, 1'b0, 0, 4'd0, 32'd0);
`ifdef IMEM_ERR_CHECK_EN
        txn(0, BASE + 32'h6, 0, 1'b0, 0, 4'd0, 32'd0);
        check("t5_err_flag", 32'(rsp_err[0]), 32'd1);
        check("t5_err_nop", rsp_data[0], 32'h13);
`else
        txn(0, BASE + 32'(4 * DEPTH + 4), 0, 1'b0, 0, 4'd0, 32'd0);
        check("t5_wrap_data", rsp_data[0], 32'h22);
        check("t5_wrap_err", 32'(rsp_err[0]), 32'd0);
`endif

        // Streaming: req_valid and rsp_ready held high, WAIT_CYCLES=2.
        ai = 0; nresp = 0; last = 0;
        req_addr[2] = BASE; req_valid[2] = 1'b1; rsp_ready[2] = 1'b1;
        for (int c = 0; c < 30 && nresp < 3; c++) begin
            check("t6_ready_vs_busy", 32'(req_ready[2]), 32'(!busy[2]));
            if (rsp_valid[2]) begin
                exp_rsp(BASE + 32'(4 * nresp), ed, ee);
                check("t6_data", rsp_data[2], ed);
                if (nresp > 0) check("t6_spacing", 32'(c - last), 32'd4);
                last = c;
                nresp++;
            end
            if (req_ready[2]) ai++;
            cyc();
            req_addr[2] = BASE + 32'(4 * ((ai < 3) ? ai : 2));
        end
        req_valid[2] = 1'b0; rsp_ready[2] = 1'b0;
        check("t6_responses", 32'(nresp), 32'd3);
        check("t6_accepts", 32'(ai), 32'd3);
        cyc();

        // Randomized transactions with loads interleaved.
        for (int n = 0; n < 40; n++) begin
            k = $urandom_range(0, NW - 1);
            if ($urandom_range(0, 2) == 0) load(4'($urandom), $urandom);
            case ($urandom_range(0, 3))
                0, 1:    a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
                2:       a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(1, 3));
                default: a = $urandom;
            endcase
            dw    = ($urandom_range(0, 1) == 1);
            wstep = $urandom_range(0, k);
            wa    = ($urandom_range(0, 1) == 1) ? 4'((a - BASE) / 4) : 4'($urandom);
            txn(k, a, $urandom_range(0, 3), dw, wstep, wa, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
